// File: rtl/riscx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscx_pkg
//  Purpose  : Shared encodings for the fetch path: next-PC select codes (same
//             values the decoder drives), fetch FSM state type, NOP word.
//             Optional macro FETCH_ALIGN_CHECK_EN adds the ERROR state.
//  Revision : 1.0  initial release
// ============================================================================
package riscx_pkg;

    // Next-PC select encodings; code 3 is reserved and behaves like PC4
    localparam logic [1:0] PC4   = 2'd0;
    localparam logic [1:0] PCBEQ = 2'd1;
    localparam logic [1:0] PCIMM = 2'd2;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t VALID = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam fetch_state_t ERROR = 2'd2;
`endif

    // addi x0, x0, 0
    localparam logic [31:0] c_nop = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next
//  Purpose  : Combinational next-PC selection (sequential, conditional
//             branch, unconditional jump). All arithmetic wraps modulo 2^32.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next
    import riscx_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        zero,
    input  logic [1:0]  orig_pc,
    output logic [31:0] next_pc
);

    logic [31:0] w_seq;
    logic [31:0] w_tgt;

    assign w_seq = pc + 32'd4;
    assign w_tgt = pc + imm;

    // Select the successor address; reserved code falls back to sequential
    always_comb begin
        next_pc = w_seq;
        case (orig_pc)
            PC4:     next_pc = w_seq;
            PCBEQ:   next_pc = zero ? w_tgt : w_seq;
            PCIMM:   next_pc = w_tgt;
            default: next_pc = w_seq;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding instruction fetch. Requests the word at pc,
//             latches it for the decoder, then steps pc when the consumer
//             advances. Optional macro FETCH_ALIGN_CHECK_EN traps misaligned
//             targets into a reset-only ERROR state; without it, target bits
//             [1:0] are cleared.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import riscx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  orig_pc,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic [31:0]  w_next_raw;
    logic [31:0]  w_next_pc;
    logic         w_take_fetch;
    logic         w_take_adv;

    pc_next u_pc_next (
        .pc      (r_pc),
        .imm     (imm),
        .zero    (zero),
        .orig_pc (orig_pc),
        .next_pc (w_next_raw)
    );

    // Data returned outside FETCH and advance outside VALID are ignored here
    assign w_take_fetch = (r_state == FETCH) && imem_ready;
    assign w_take_adv   = (r_state == VALID) && advance;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_bad;

    assign w_next_pc = w_next_raw;
    assign w_bad     = (w_next_raw[1:0] != 2'b00);
    assign misalign  = r_misalign;

    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_misalign <= 1'b0;
        else if (w_take_adv && w_bad)
            r_misalign <= 1'b1;
    end
`else
    assign w_next_pc = w_next_raw & ~32'd3;
    assign misalign  = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= FETCH;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: if (imem_ready) w_state_next = VALID;
            VALID: begin
                if (advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    w_state_next = w_bad ? ERROR : FETCH;
`else
                    w_state_next = FETCH;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ERROR: w_state_next = ERROR;
`endif
            default: w_state_next = FETCH;
        endcase
    end

    // Request outputs; request is withdrawn the moment reset asserts
    always_comb begin
        imem_req  = (r_state == FETCH) && !reset;
        imem_addr = r_pc;
    end

    // PC, instruction latch and valid flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= c_nop;
            r_valid <= 1'b0;
        end else begin
            if (w_take_fetch) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_take_adv) begin
                r_pc    <= w_next_pc;
                r_valid <= 1'b0;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instruction = r_instr;
    assign instr_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed vector bench for fetch_unit: table of fetch/advance
//             records plus hand sequences for reset abort and misalignment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import riscx_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  orig_pc;
    logic        zero;
    logic [31:0] imm;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          waits;
        int          hold;
        logic [1:0]  sel;
        logic        zero;
        logic [31:0] imm;
        logic [31:0] next;
    } vec_t;

    vec_t tbl [10];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .orig_pc     (orig_pc),
        .zero        (zero),
        .imm         (imm),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .misalign    (misalign)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait out 'waits' cycles with ready low (advance high, which must be ignored), then return data
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int waits);
        for (int w = 0; w <= waits; w++) begin
            @(negedge clock);
            chk("req_in_fetch", {31'd0, imem_req}, 32'd1);
            chk("addr_in_fetch", imem_addr, a);
            chk("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
            imem_ready = (w == waits);
            imem_rdata = (w == waits) ? d : 32'hDEAD_BEEF;
            advance    = (w < waits);
        end
        @(negedge clock);
        imem_ready = 1'b0;
        advance    = 1'b0;
        chk("valid_after_fetch", {31'd0, instr_valid}, 32'd1);
        chk("instr_after_fetch", instruction, d);
        chk("pc_after_fetch", pc, a);
        chk("pc_plus4", pc_plus4, a + 32'd4);
        chk("req_in_valid", {31'd0, imem_req}, 32'd0);
    endtask

    // Sit in VALID with random memory activity; nothing may change
    task automatic do_hold(input logic [31:0] a, input logic [31:0] d, input int hold);
        for (int h = 0; h < hold; h++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clock);
            chk("hold_instr", instruction, d);
            chk("hold_pc", pc, a);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ready = 1'b0;
    endtask

    task automatic do_advance(input logic [1:0] sel, input logic z, input logic [31:0] im,
                              input logic [31:0] nxt);
        orig_pc = sel;
        zero    = z;
        imm     = im;
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        orig_pc = PC4;
        zero    = 1'b0;
        imm     = 32'd0;
        chk("valid_after_adv", {31'd0, instr_valid}, 32'd0);
        chk("req_after_adv", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, nxt);
        chk("misalign_clear", {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        orig_pc    = PC4;
        zero       = 1'b0;
        imm        = 32'd0;
        advance    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;

        tbl[0] = '{32'h0000_0000, 32'h0010_0093, 1, 3,  PCIMM, 1'b0, 32'h0000_0100, 32'h0000_0100};
        tbl[1] = '{32'h0000_0100, 32'h0020_8463, 0, 10, PCBEQ, 1'b1, 32'h0000_0020, 32'h0000_0120};
        tbl[2] = '{32'h0000_0120, 32'h1111_1111, 2, 1,  PCIMM, 1'b0, 32'hFFFF_FFE0, 32'h0000_0100};
        tbl[3] = '{32'h0000_0100, 32'h2222_2222, 0, 2,  PCBEQ, 1'b0, 32'h0000_0020, 32'h0000_0104};
        tbl[4] = '{32'h0000_0104, 32'h3333_3333, 1, 0,  2'd3,  1'b1, 32'h0000_0040, 32'h0000_0108};
        tbl[5] = '{32'h0000_0108, 32'h4444_4444, 0, 1,  PC4,   1'b1, 32'h0000_0080, 32'h0000_010C};
        tbl[6] = '{32'h0000_010C, 32'h5555_5555, 0, 0,  PCIMM, 1'b0, 32'hFFFF_FEF0, 32'hFFFF_FFFC};
        tbl[7] = '{32'hFFFF_FFFC, 32'h6666_6666, 1, 1,  PC4,   1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[8] = '{32'h0000_0000, 32'h7777_7777, 0, 0,  PCBEQ, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        tbl[9] = '{32'hFFFF_FFF8, 32'h8888_8888, 0, 0,  PCIMM, 1'b0, 32'h0000_0048, 32'h0000_0040};

        // Reset state
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Table-driven fetch / advance records
        for (int i = 0; i < 10; i++) begin
            do_fetch(tbl[i].pc, tbl[i].rdata, tbl[i].waits);
            do_hold(tbl[i].pc, tbl[i].rdata, tbl[i].hold);
            do_advance(tbl[i].sel, tbl[i].zero, tbl[i].imm, tbl[i].next);
        end

        // Reset pulsed during an outstanding fetch at 0x40 with ready low
        #2 reset = 1'b1;
        #1;
        chk("rstmid_req", {31'd0, imem_req}, 32'd0);
        chk("rstmid_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstmid_pc", pc, 32'h0);
        chk("rstmid_instr", instruction, 32'h0000_0013);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rstrel_req", {31'd0, imem_req}, 32'd1);
        chk("rstrel_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'h9999_9999, 0);
        do_advance(PCIMM, 1'b0, 32'h0000_0040, 32'h0000_0040);
        do_fetch(32'h40, 32'hAAAA_AAAA, 2);

        // Misaligned jump target
        orig_pc = PCIMM;
        imm     = 32'h2;
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        orig_pc = PC4;
        imm     = 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            chk("mis_flag", {31'd0, misalign}, 32'd1);
            chk("mis_req", {31'd0, imem_req}, 32'd0);
            chk("mis_valid", {31'd0, instr_valid}, 32'd0);
            chk("mis_pc", pc, 32'h42);
            imem_ready = 1'b1;
            advance    = 1'b1;
            @(negedge clock);
        end
        imem_ready = 1'b0;
        advance    = 1'b0;
`else
        chk("mis_flag", {31'd0, misalign}, 32'd0);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        do_fetch(32'h40, 32'hBBBB_BBBB, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 orig_pc  in  2  next-PC select: 0=PC4, 1=PCBEQ, 2=PCIMM, 3=reserved.
REQ-005 zero  in  1  ALU zero flag, used by PCBEQ.
REQ-006 imm  in  32  sign-extended branch/jump offset.
REQ-007 advance  in  1  consumer has taken the current instruction.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  instruction memory byte address.
REQ-010 imem_ready  in  1  memory has returned data this cycle.
REQ-011 imem_rdata  in  32  instruction word from memory.
REQ-012 instruction  out  32  latched instruction, fed to the decoder.
REQ-013 pc  out  32  address of the latched instruction.
REQ-014 pc_plus4  out  32  pc+4, the write-back source for jumps.
REQ-015 instr_valid  out  1  instruction/pc outputs hold a valid fetch.
REQ-016 misalign  out  1  sticky misaligned-target flag; tied to 0 when the check is compiled out.

Function
REQ-017 SHALL implement FSM states FETCH, VALID, ERROR.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc, both combinational from state; address held stable until imem_ready.
REQ-019 In FETCH with imem_ready=1: latch imem_rdata into instruction, set instr_valid=1 next cycle, go to VALID; one-cycle minimum fetch latency.
REQ-020 In VALID: imem_req=0; instruction, pc and instr_valid held while advance=0.
REQ-021 In VALID with advance=1: pc loads next_pc, instr_valid drops next cycle, go to FETCH.
REQ-022 next_pc rules:
  - PC4: pc+4.
  - PCBEQ: pc+imm when zero=1, else pc+4.
  - PCIMM: pc+imm.
  - reserved (3): pc+4.
REQ-023 All PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-024 advance asserted in FETCH SHALL be ignored.
REQ-025 imem_ready asserted outside FETCH SHALL be ignored.
REQ-026 pc_plus4 SHALL always equal pc+4, combinational.

Reset
REQ-027 On reset assertion, immediately and asynchronously:
  - state=FETCH, pc=RESET_PC.
  - instruction=32'h0000_0013 (NOP).
  - instr_valid=0, misalign=0.
REQ-028 Reset mid-fetch SHALL abandon the outstanding request; any data returned after reset releases is accepted only for address RESET_PC.
REQ-029 The first request SHALL be issued in the first cycle after reset deassertion, with imem_addr=RESET_PC.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: a next_pc with bits[1:0]!=0 SHALL load pc, set misalign=1, and move to ERROR. ERROR issues no requests, keeps instr_valid=0, and is left only by reset.
REQ-031 Macro FETCH_ALIGN_CHECK_EN undefined: next_pc[1:0] SHALL be forced to 2'b00, misalign tied to 0, and the ERROR state not generated.

Structure
REQ-032 Shared package riscx_pkg SHALL hold:
  - the orig_pc encodings PC4/PCBEQ/PCIMM, identical to the decoder's values.
  - the fetch FSM state type.
  - the NOP constant 32'h0000_0013.
REQ-033 Next-PC computation SHALL live in the combinational sub-module pc_next (inputs: pc, imm, zero, orig_pc; output: next_pc).

Verification
REQ-034 Reset with RESET_PC=0; imem_ready=1 on the second request cycle -> imem_addr=0 for two cycles, then instruction=rdata, instr_valid=1, pc=0.
REQ-035 pc=0x100, orig_pc=PCBEQ, imm=0x20, zero=1, advance=1 -> next fetch at 0x120; repeated with zero=0 -> next fetch at 0x104.
REQ-036 pc=0xFFFF_FFFC, orig_pc=PC4, advance=1 -> next imem_addr=0x0000_0000.
REQ-037 Reset pulsed during FETCH while imem_ready=0 -> imem_req drops in the same cycle, instr_valid=0, and fetch restarts at RESET_PC.
REQ-038 With FETCH_ALIGN_CHECK_EN, pc=0x40, orig_pc=PCIMM, imm=0x2, advance=1 -> misalign=1, imem_req stays 0; without the macro -> next fetch at 0x40.
REQ-039 In VALID with advance=0 for 10 cycles and random imem_ready -> instruction and pc unchanged, imem_req=0.
